// File: rtl/fsm_seq_ctrl.sv
// Symbol-burst sequencer for the 2-bit-symbol Mealy recognizer.
// A producer fills a small buffer while the block is idle. A start command
// clears the recognizer for one cycle and replays the buffered symbols at one
// per clock. The recognizer's z pulses are counted, saturating at the top of
// the counter. The buffer survives a replay, so the same burst can be replayed.
module fsm_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_sym,
    input  logic             buf_clr,
    input  logic             start,
    input  logic             z_in,
    output logic [1:0]       sym_out,
    output logic             sym_valid,
    output logic             rec_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] level,
    output logic             full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The fill count needs one more bit than the address so it can hold DEPTH.
    localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      ONE_CNT   = (AW+1)'(1);
    localparam logic [CNT_W-1:0] HITS_MAX  = '1;

    state_t            state_reg;
    state_t            state_next;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       lvl_reg;
    logic              full_reg;
    logic [CNT_W-1:0]  hits_reg;
    logic [1:0]        rd_data_reg;
    logic [1:0]        mem [DEPTH];

    // Decoded one-per-cycle actions and the buffer read address
    logic              do_clr;
    logic              do_write;
    logic [AW-1:0]     rd_addr;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, outputs and IDLE command decode (buf_clr > start > wr_en).
    // The read address runs one entry ahead of rd_ptr so the registered
    // buffer read already holds buf[rd_ptr] during each RUN cycle.
    always_comb begin
        state_next = state_reg;
        rec_clr    = 1'b0;
        sym_valid  = 1'b0;
        sym_out    = 2'b00;
        done       = 1'b0;
        busy       = 1'b1;
        do_clr     = 1'b0;
        do_write   = 1'b0;
        rd_addr    = rd_ptr_reg + 1'b1;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (buf_clr) begin
                    do_clr = 1'b1;
                end else if (start) begin
                    if (lvl_reg != '0) begin
                        state_next = S_CLR;
                    end
                end else if (wr_en && !full_reg) begin
                    do_write = 1'b1;
                end
            end
            S_CLR: begin
                rec_clr    = 1'b1;
                rd_addr    = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                sym_valid = 1'b1;
                sym_out   = rd_data_reg;
                if ({1'b0, rd_ptr_reg} == lvl_reg - ONE_CNT) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Pointers, fill level, full flag and saturating hit counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            lvl_reg    <= '0;
            full_reg   <= 1'b0;
            hits_reg   <= '0;
        end else begin
            if (do_clr) begin
                wr_ptr_reg <= '0;
                lvl_reg    <= '0;
                full_reg   <= 1'b0;
            end else if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                lvl_reg    <= lvl_reg + ONE_CNT;
                full_reg   <= (lvl_reg + ONE_CNT == DEPTH_CNT);
            end
            if (state_reg == S_CLR) begin
                rd_ptr_reg <= '0;
                hits_reg   <= '0;
            end else if (state_reg == S_RUN) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (z_in && hits_reg != HITS_MAX) begin
                    hits_reg <= hits_reg + 1'b1;
                end
            end
        end
    end

    // Symbol buffer: write port from the producer, registered read port
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= wr_sym;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign hits  = hits_reg;
    assign level = CNT_W'(lvl_reg);
    assign full  = full_reg;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: a replay-timeline model (burst queue plus a phase
// index counted from the accepted start) predicts every output each cycle.
// A second instance with a 3-bit counter and z tied high exercises saturation.
module tb_fsm_seq_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CNT_W = 5;
    localparam int SW    = 3;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en   = 1'b0;
    logic [1:0]       wr_sym  = 2'b00;
    logic             buf_clr = 1'b0;
    logic             start   = 1'b0;
    logic             z_in    = 1'b0;

    logic [1:0]       sym_out;
    logic             sym_valid, rec_clr, busy, done, full;
    logic [CNT_W-1:0] hits, level;

    logic [1:0]       s_sym_out;
    logic             s_sym_valid, s_rec_clr, s_busy, s_done, s_full;
    logic [SW-1:0]    s_hits, s_level;

    always #5 clock = ~clock;

    fsm_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_sym(wr_sym),
        .buf_clr(buf_clr), .start(start), .z_in(z_in),
        .sym_out(sym_out), .sym_valid(sym_valid), .rec_clr(rec_clr),
        .busy(busy), .done(done), .hits(hits), .level(level), .full(full)
    );

    fsm_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .CNT_W(SW)) u_sat (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_sym(wr_sym),
        .buf_clr(buf_clr), .start(start), .z_in(1'b1),
        .sym_out(s_sym_out), .sym_valid(s_sym_valid), .rec_clr(s_rec_clr),
        .busy(s_busy), .done(s_done), .hits(s_hits), .level(s_level), .full(s_full)
    );

    // Model: stored burst, and position in the replay timeline.
    // Phase 0 = recognizer clear, 1..L = symbols, L+1 = done.
    logic [1:0] mbuf[$];
    bit         mact;
    int         mph;
    int         mhits;
    int         mshits;
    int         zmode;
    int         cyc;
    int         done_at;
    int         tests;
    int         fails;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit e_valid();
        return mact && (mph >= 1) && (mph <= mbuf.size());
    endfunction

    function automatic logic [1:0] e_sym();
        if (e_valid()) return mbuf[mph-1];
        return 2'b00;
    endfunction

    // Per-cycle comparison of both instances against the model
    task automatic compare_all();
        int L;
        L = mbuf.size();
        chk("busy",      busy,      mact);
        chk("rec_clr",   rec_clr,   mact && mph == 0);
        chk("sym_valid", sym_valid, e_valid());
        chk("sym_out",   sym_out,   e_sym());
        chk("done",      done,      mact && mph == L + 1);
        chk("hits",      hits,      mhits);
        chk("level",     level,     L);
        chk("full",      full,      L == DEPTH);
        chk("s_busy",    s_busy,    mact);
        chk("s_rec_clr", s_rec_clr, mact && mph == 0);
        chk("s_valid",   s_sym_valid, e_valid());
        chk("s_sym_out", s_sym_out, e_sym());
        chk("s_done",    s_done,    mact && mph == L + 1);
        chk("s_hits",    s_hits,    mshits);
        chk("s_level",   s_level,   L % 8);
        chk("s_full",    s_full,    L == DEPTH);
    endtask

    task automatic model_edge(input bit wr, input logic [1:0] sym, input bit clr,
                              input bit st, input bit z);
        int L;
        L = mbuf.size();
        if (!mact) begin
            if (clr) mbuf.delete();
            else if (st) begin
                if (L > 0) begin
                    mact = 1;
                    mph  = 0;
                end
            end else if (wr && L < DEPTH) mbuf.push_back(sym);
        end else begin
            if (mph == 0) begin
                mhits  = 0;
                mshits = 0;
            end
            if (mph >= 1 && mph <= L) begin
                if (z && mhits < 31) mhits++;
                if (mshits < 7) mshits++;
            end
            if (mph == L + 1) mact = 0;
            else mph++;
        end
    endtask

    task automatic cycle(input bit wr, input logic [1:0] sym, input bit clr, input bit st);
        @(negedge clock);
        compare_all();
        if (done) done_at = cyc + 1;
        wr_en   = wr;
        wr_sym  = sym;
        buf_clr = clr;
        start   = st;
        if (zmode == 0)      z_in = 1'($urandom_range(0, 1));
        else if (zmode == 1) z_in = e_valid() && (e_sym() == 2'b11);
        else                 z_in = 1'b1;
        @(posedge clock);
        cyc++;
        model_edge(wr, sym, clr, st, z_in);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        mbuf.delete();
        mact   = 0;
        mph    = 0;
        mhits  = 0;
        mshits = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once
    task automatic mid_reset();
        #2;
        wr_en = 0; buf_clr = 0; start = 0; z_in = 0;
        reset_n = 1'b0;
        #1;
        chk("rst_busy",  busy,      0);
        chk("rst_valid", sym_valid, 0);
        chk("rst_sym",   sym_out,   0);
        chk("rst_clr",   rec_clr,   0);
        chk("rst_done",  done,      0);
        chk("rst_hits",  hits,      0);
        chk("rst_level", level,     0);
        chk("rst_full",  full,      0);
        model_reset();
        @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    logic [1:0] burst9 [9];

    initial begin
        tests = 0; fails = 0; cyc = 0; zmode = 1; done_at = -1;
        model_reset();
        burst9 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd1, 2'd1};

        // Power-on reset
        @(posedge clock);
        mid_reset();

        // Stub recognizer: z for symbol C only -> exactly one hit
        zmode = 1;
        foreach (burst9[i]) cycle(1'b1, burst9[i], 1'b0, 1'b0);
        done_at = -1;
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        begin
            int start_cyc;
            start_cyc = cyc;
            idle(12);
            chk("done_latency", done_at - start_cyc, 11);
        end
        #1;
        chk("stub_hits", hits, 1);
        chk("stub_level", level, 9);

        // z held high: 9 hits, again 9 on the repeated replay; small counter saturates
        zmode = 2;
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(12);
        #1;
        chk("z1_hits", hits, 9);
        chk("sat_hits", s_hits, 7);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(12);
        #1;
        chk("z1_hits_again", hits, 9);

        // Commands during a replay are ignored
        zmode = 0;
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        repeat (9) cycle(1'b1, 2'b10, 1'b1, 1'b1);
        idle(4);
        #1;
        chk("busy_ignore_level", level, 9);

        // Reset in the third symbol cycle of a 9-symbol replay
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(3);
        mid_reset();
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(3);
        #1;
        chk("post_rst_level", level, 0);
        chk("post_rst_busy", busy, 0);

        // Fill to DEPTH, overflow write dropped, full replay in order
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 2'(i), 1'b0, 1'b0);
        #1;
        chk("full_at_16", full, 1);
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        #1;
        chk("level_16", level, 16);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(20);

        // Start with empty buffer; buf_clr wins over same-cycle start
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'b01, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b1, 1'b1);
        #1;
        chk("clr_start_level", level, 0);
        idle(3);
        #1;
        chk("clr_start_busy", busy, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 31) == 0) zmode = int'($urandom_range(0, 2));
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0);
        end
        idle(25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
